// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a 1W/1R SRAM macro; a 2-entry output buffer
// absorbs the macro's one-cycle read latency so the FIFO streams one word per cycle.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_inflight;
    logic [1:0]            r_ob_cnt;
    logic [DATA_WIDTH-1:0] r_ob0;
    logic [DATA_WIDTH-1:0] r_ob1;

    logic [ADDR_WIDTH:0]   w_sram_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic [2:0]            w_lim;
    logic [1:0]            w_tail;

    assign w_sram_cnt = r_wr_ptr - r_rd_ptr;
    assign s_ready    = ~rst & (w_sram_cnt < L_DEPTH);
    assign w_push     = s_valid & s_ready;

    assign m_valid    = (r_ob_cnt != 2'd0);
    assign m_data     = r_ob0;
    assign w_pop      = m_valid & m_ready;

    // Buffer slots already claimed (held or in flight) must leave room for the new read.
    assign w_occ      = {1'b0, r_ob_cnt} + {2'b00, r_inflight};
    assign w_lim      = 3'd2 + {2'b00, w_pop};
    assign w_issue    = ~rst & (w_sram_cnt != '0) & (w_occ < w_lim);

    assign sram_csb0  = ~w_push;
    assign sram_addr0 = r_wr_ptr[ADDR_WIDTH-1:0];
    assign sram_din0  = s_data;
    assign sram_csb1  = ~w_issue;
    assign sram_addr1 = r_rd_ptr[ADDR_WIDTH-1:0];

    assign w_tail     = r_ob_cnt - {1'b0, w_pop};

    assign count = {1'b0, w_sram_cnt}
                 + {{(ADDR_WIDTH + 1){1'b0}}, r_inflight}
                 + {{ADDR_WIDTH{1'b0}}, r_ob_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_ob_cnt   <= 2'd0;
            r_ob0      <= '0;
            r_ob1      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_inflight <= w_issue;
            r_ob_cnt   <= r_ob_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
            if (w_pop) begin
                r_ob0 <= r_ob1;
            end
            // Capture lands at the tail as seen after this cycle's pop.
            if (r_inflight) begin
                if (w_tail == 2'd0) begin
                    r_ob0 <= sram_dout1;
                end else begin
                    r_ob1 <= sram_dout1;
                end
            end
        end
    end

endmodule
